// File: rtl/param_up_down_counter.sv
// -----------------------------------------------------------------------------
// param_up_down_counter
//
// Start-triggered sweep/ramp generator. When a start is accepted, the counter
// latches a mode and an upper limit. It then counts between 0 and that limit
// in one of four modes:
//   00 single bounce     : 0 -> limit -> 0, then completion
//   01 continuous bounce : 0 -> limit -> 0 -> limit ... until stop/reset
//   10 up-only           : 0 -> limit, then completion
//   11 down-only         : limit -> 0, then completion
// A controller can pause the sweep with in_hold and abort it with in_stop.
// out_done pulses for one cycle on normal completion.
//
// Parameters:
//   WIDTH  : width of out_value / in_limit (2..16)
//   CYC_W  : width of out_cycles (only present with UDC_CYCLE_COUNT_EN)
//
// Ports:
//   in_clock   : clock, all state updates on the rising edge
//   in_reset   : synchronous, active-high reset
//   in_start   : start request, accepted only while out_ready=1
//   in_stop    : abort to IDLE (value 0, no done pulse)
//   in_hold    : freeze state/value/dir while busy
//   in_mode    : sweep mode, latched on start
//   in_limit   : top count value, latched on start
//   out_ready  : 1 while IDLE and able to accept a start
//   out_value  : current count
//   out_dir    : 1 while counting down
//   out_done   : one-cycle completion pulse, coincident with first IDLE cycle
//   out_cycles : (UDC_CYCLE_COUNT_EN only) saturating count of DOWN->0
//                turnarounds/completions, or up-only completions
//
// Optional feature macro: UDC_CYCLE_COUNT_EN
//   Defined   -> out_cycles port and its counter exist.
//   Undefined -> port and logic are absent; behaviour is otherwise identical.
// -----------------------------------------------------------------------------
module param_up_down_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CYC_W = 16
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic             in_start,
  input  logic             in_stop,
  input  logic             in_hold,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_limit,
  output logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_dir,
  output logic             out_done
`ifdef UDC_CYCLE_COUNT_EN
  ,
  output logic [CYC_W-1:0] out_cycles
`endif
);

  // Reject parameter values outside the supported range at elaboration.
  generate
    if ((WIDTH < 32'd2) || (WIDTH > 32'd16) || (CYC_W < 32'd1)) begin : g_bad_param
      $error("param_up_down_counter: WIDTH must be 2..16 and CYC_W >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_CONT   = 2'b01;
  localparam logic [1:0] MODE_UP     = 2'b10;
  localparam logic [1:0] MODE_DOWN   = 2'b11;

  localparam logic [WIDTH-1:0] VAL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] VAL_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Registered state and outputs
  state_t           state_r;
  logic [WIDTH-1:0] value_r;
  logic             dir_r;
  logic             done_r;
  logic             ready_r;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] limit_r;

  // Next-state values
  state_t           state_s;
  logic [WIDTH-1:0] value_s;
  logic             dir_s;
  logic             done_s;
  logic             ready_s;
  logic [1:0]       mode_s;
  logic [WIDTH-1:0] limit_s;

  // Decoded conditions on the current registered state
  logic             at_top_s;
  logic             at_zero_s;
  logic             busy_s;

  // Decode the turnaround conditions from the current count.
  always_comb begin
    at_top_s  = (value_r == limit_r);
    at_zero_s = (value_r == VAL_ZERO);
    busy_s    = (state_r != ST_IDLE);
  end

  // Next-state / next-output logic: stop beats hold beats normal counting.
  always_comb begin
    state_s = state_r;
    value_s = value_r;
    done_s  = 1'b0;
    mode_s  = mode_r;
    limit_s = limit_r;

    if (in_stop) begin
      // Abort from any state, including a start arriving in the same cycle.
      state_s = ST_IDLE;
      value_s = VAL_ZERO;
    end else if (in_hold && busy_s) begin
      // Frozen: everything keeps its current value, no completion pulse.
      state_s = state_r;
      value_s = value_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          value_s = VAL_ZERO;
          if (in_start) begin
            mode_s  = in_mode;
            limit_s = in_limit;
            if (in_limit == VAL_ZERO) begin
              // Degenerate sweep: nothing to count, complete immediately.
              state_s = ST_IDLE;
              done_s  = 1'b1;
            end else if (in_mode == MODE_DOWN) begin
              state_s = ST_DOWN;
              value_s = in_limit;
            end else begin
              state_s = ST_UP;
              value_s = VAL_ZERO;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end

        ST_UP: begin
          if (!at_top_s) begin
            value_s = value_r + VAL_ONE;
          end else if (mode_r == MODE_UP) begin
            state_s = ST_IDLE;
            value_s = VAL_ZERO;
            done_s  = 1'b1;
          end else begin
            // Peak has been shown for exactly one cycle; turn around.
            state_s = ST_DOWN;
            value_s = value_r - VAL_ONE;
          end
        end

        ST_DOWN: begin
          if (!at_zero_s) begin
            value_s = value_r - VAL_ONE;
          end else if (mode_r == MODE_CONT) begin
            // Zero has been shown for exactly one cycle; bounce back up.
            state_s = ST_UP;
            value_s = VAL_ONE;
          end else begin
            state_s = ST_IDLE;
            value_s = VAL_ZERO;
            done_s  = 1'b1;
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean IDLE.
          state_s = ST_IDLE;
          value_s = VAL_ZERO;
        end
      endcase
    end

    // Direction and readiness follow directly from the next state.
    dir_s   = (state_s == ST_DOWN);
    ready_s = (state_s == ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_r <= ST_IDLE;
      value_r <= VAL_ZERO;
      dir_r   <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
      mode_r  <= MODE_SINGLE;
      limit_r <= VAL_ZERO;
    end else begin
      state_r <= state_s;
      value_r <= value_s;
      dir_r   <= dir_s;
      done_r  <= done_s;
      ready_r <= ready_s;
      mode_r  <= mode_s;
      limit_r <= limit_s;
    end
  end

  // Drive the ports straight from registers.
  always_comb begin
    out_ready = ready_r;
    out_value = value_r;
    out_dir   = dir_r;
    out_done  = done_r;
  end

`ifdef UDC_CYCLE_COUNT_EN
  localparam logic [CYC_W-1:0] CYC_ZERO = {CYC_W{1'b0}};
  localparam logic [CYC_W-1:0] CYC_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] CYC_MAX  = {CYC_W{1'b1}};

  logic [CYC_W-1:0] cycles_r;
  logic [CYC_W-1:0] cycles_s;
  logic             cyc_event_s;
  logic             cyc_clear_s;

  // Count events: every DOWN-at-zero edge (bounce or completion; only the
  // bounce modes and down-only ever reach DOWN) and up-only completions.
  always_comb begin
    cyc_clear_s = (!in_stop) && (state_r == ST_IDLE) && in_start;
    cyc_event_s = (!in_stop) && (!in_hold) &&
                  (((state_r == ST_DOWN) && at_zero_s) ||
                   ((state_r == ST_UP) && (mode_r == MODE_UP) && at_top_s));
    if (cyc_clear_s) begin
      cycles_s = CYC_ZERO;
    end else if (cyc_event_s && (cycles_r != CYC_MAX)) begin
      cycles_s = cycles_r + CYC_ONE;
    end else begin
      cycles_s = cycles_r;
    end
  end

  // Saturating cycle counter register.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      cycles_r <= CYC_ZERO;
    end else begin
      cycles_r <= cycles_s;
    end
  end

  // Expose the counter register.
  always_comb begin
    out_cycles = cycles_r;
  end
`endif

endmodule

// File: tb/tb_param_up_down_counter.sv
// -----------------------------------------------------------------------------
// tb_param_up_down_counter
//
// Scoreboard bench. The driver applies one input vector per clock; at each
// rising edge a sweep-level reference model (step index k into an
// arithmetically defined triangle/ramp) advances and the expected outputs
// are pushed into a queue. A separate monitor pops one entry per falling
// edge and compares it to the DUT outputs.
// -----------------------------------------------------------------------------
module tb_param_up_down_counter;

  localparam int W  = 8;
  localparam int CW = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stop;
  logic         hold;
  logic [1:0]   mode;
  logic [W-1:0] limit;
  logic         ready;
  logic [W-1:0] value;
  logic         dir;
  logic         done;
`ifdef UDC_CYCLE_COUNT_EN
  logic [CW-1:0] cycles;
`endif

  param_up_down_counter #(.WIDTH(W), .CYC_W(CW)) dut (
    .in_clock  (clk),
    .in_reset  (rst),
    .in_start  (start),
    .in_stop   (stop),
    .in_hold   (hold),
    .in_mode   (mode),
    .in_limit  (limit),
    .out_ready (ready),
    .out_value (value),
    .out_dir   (dir),
    .out_done  (done)
`ifdef UDC_CYCLE_COUNT_EN
    ,
    .out_cycles(cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rdy;
    logic [W-1:0]  val;
    logic          dn;
    logic          dne;
    logic [CW-1:0] cyc;
  } exp_t;

  exp_t  exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  string phase       = "reset";

  // Reference model: idle/busy, latched sweep, step index into the sweep.
  bit m_busy = 1'b0;
  int m_mode = 0;
  int m_lim  = 0;
  int m_k    = 0;
  bit m_done = 1'b0;
  int m_cyc  = 0;

  function automatic bit m_last();
    case (m_mode)
      0:       return (m_k == 2 * m_lim);
      1:       return 1'b0;
      default: return (m_k == m_lim);
    endcase
  endfunction

  function automatic void model_step(bit r, bit sp, bit h, bit sa, int md, int lm);
    if (r) begin
      m_busy = 1'b0; m_done = 1'b0; m_k = 0; m_cyc = 0;
    end else if (sp) begin
      m_busy = 1'b0; m_done = 1'b0;
    end else if (h && m_busy) begin
      m_done = 1'b0;
    end else if (!m_busy) begin
      m_done = 1'b0;
      if (sa) begin
        m_mode = md; m_lim = lm; m_k = 0; m_cyc = 0;
        if (lm == 0) m_done = 1'b1;
        else         m_busy = 1'b1;
      end
    end else begin
      if (m_last()) begin
        m_busy = 1'b0; m_done = 1'b1; m_cyc = m_cyc + 1;
      end else begin
        // Continuous mode: leaving a zero that follows a descent.
        if (m_mode == 1 && m_k > 0 && (m_k % (2 * m_lim)) == 0) m_cyc = m_cyc + 1;
        m_k = m_k + 1;
      end
    end
    if (m_cyc > (1 << CW) - 1) m_cyc = (1 << CW) - 1;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   p;
    e     = '0;
    e.cyc = CW'(m_cyc);
    e.dne = m_done;
    if (!m_busy) begin
      e.rdy = 1'b1; e.val = '0; e.dn = 1'b0;
    end else begin
      e.rdy = 1'b0;
      case (m_mode)
        0: begin
          e.val = W'((m_k <= m_lim) ? m_k : 2 * m_lim - m_k);
          e.dn  = (m_k > m_lim);
        end
        1: begin
          p     = m_k % (2 * m_lim);
          e.val = W'((p <= m_lim) ? p : 2 * m_lim - p);
          e.dn  = (p > m_lim) || (p == 0 && m_k > 0);
        end
        2: begin
          e.val = W'(m_k); e.dn = 1'b0;
        end
        default: begin
          e.val = W'(m_lim - m_k); e.dn = 1'b1;
        end
      endcase
    end
    return e;
  endfunction

  // One clock: model advances on the same edge the DUT samples.
  task automatic tick();
    @(posedge clk);
    model_step(rst, stop, hold, start, int'(mode), int'(limit));
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic kick(logic [1:0] md, logic [W-1:0] lm);
    start = 1'b1; mode = md; limit = lm;
    tick();
    start = 1'b0;
  endtask

  // Monitor: compare DUT outputs with the oldest expectation.
  exp_t mon_e;
  bit   mon_bad;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      vectors = vectors + 1;
      mon_bad = (ready !== mon_e.rdy) || (value !== mon_e.val) ||
                (dir !== mon_e.dn) || (done !== mon_e.dne);
`ifdef UDC_CYCLE_COUNT_EN
      if (cycles !== mon_e.cyc) begin
        mon_bad = 1'b1;
        $display("FAIL %s cycles: got %0d expected %0d at %0t", phase, cycles, mon_e.cyc, $time);
      end
`endif
      if (mon_bad) begin
        miscompares = miscompares + 1;
        $display("FAIL %s: got ready=%0b value=%0d dir=%0b done=%0b, expected ready=%0b value=%0d dir=%0b done=%0b at %0t",
                 phase, ready, value, dir, done, mon_e.rdy, mon_e.val, mon_e.dn, mon_e.dne, $time);
      end
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 2'b00; limit = '0;
    phase = "reset";
    run(3);
    rst = 1'b0;
    run(2);

    phase = "single_l3";
    kick(2'b00, 8'd3);
    run(10);

    phase = "cont_l2_stop";
    kick(2'b01, 8'd2);
    run(9);
    stop = 1'b1; tick(); stop = 1'b0;
    run(3);

    phase = "up_l5_hold";
    kick(2'b10, 8'd5);
    run(2);
    hold = 1'b1; run(3); hold = 1'b0;
    run(8);

    phase = "down_l4_restart";
    kick(2'b11, 8'd4);
    run(2);
    start = 1'b1; limit = 8'd9; mode = 2'b00; tick(); start = 1'b0;
    run(6);

    phase = "limit0";
    kick(2'b00, 8'd0);
    run(3);

    phase = "single_l255";
    kick(2'b00, 8'd255);
    run(515);

    phase = "reset_mid_down";
    kick(2'b00, 8'd6);
    run(9);
    rst = 1'b1; tick(); rst = 1'b0;
    run(2);

    phase = "cont_l1_bounces";
    kick(2'b01, 8'd1);
    run(7);
    stop = 1'b1; tick(); stop = 1'b0;
    run(2);

    phase = "stop_with_start";
    stop = 1'b1; start = 1'b1; mode = 2'b00; limit = 8'd2; tick();
    stop = 1'b0; start = 1'b0;
    run(3);

    phase = "hold_in_idle";
    hold = 1'b1; kick(2'b00, 8'd2);
    hold = 1'b0;
    run(7);

    phase = "random";
    for (int i = 0; i < 2500; i++) begin
      rst   = ($urandom_range(0, 127) == 0);
      stop  = ($urandom_range(0, 47) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      start = ($urandom_range(0, 3) == 0);
      mode  = 2'($urandom_range(0, 3));
      limit = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 6));
      tick();
    end
    rst = 1'b0; stop = 1'b0; hold = 1'b0; start = 1'b0;

    phase = "drain";
    repeat (3) @(negedge clk);
    vectors = vectors + 1;
    if (exp_q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
